// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: arbitrates exceptions, interrupts and MRET,
// then sequences the PC mux, CSR update strobes and pipeline flush.
module trap_ctrl #(
    parameter logic [1:0] PC_BOOT = 2'b00,
    parameter logic [1:0] PC_EPC  = 2'b01,
    parameter logic [1:0] PC_TRAP = 2'b10,
    parameter logic [1:0] PC_NEXT = 2'b11
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       instr_valid_in,
    input  logic       misaligned_instr_in,
    input  logic       illegal_instr_in,
    input  logic       ebreak_in,
    input  logic       ecall_in,
    input  logic       misaligned_load_in,
    input  logic       misaligned_store_in,
    input  logic       mret_in,
    input  logic       mie_in,
    input  logic       meie_in,
    input  logic       msie_in,
    input  logic       mtie_in,
    input  logic       meip_in,
    input  logic       msip_in,
    input  logic       mtip_in,
    output logic       int_or_exc_out,
    output logic [3:0] cause_out,
    output logic [1:0] pc_src_out,
    output logic       set_epc_out,
    output logic       set_cause_out,
    output logic       mie_clear_out,
    output logic       mie_set_out,
    output logic       flush_out
);

    typedef enum logic [1:0] {
        S_RESET,
        S_OPERATING,
        S_TRAP_TAKEN,
        S_TRAP_RETURN
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_cause;
    logic       r_int_or_exc;
    logic [3:0] w_cause;
    logic       w_int_or_exc;
    logic       w_exc;
    logic       w_int;
    logic       w_take;

    always_comb begin
        w_exc = instr_valid_in & (misaligned_instr_in | illegal_instr_in |
                ebreak_in | ecall_in | misaligned_load_in |
                misaligned_store_in);
        w_int = instr_valid_in & mie_in & ((meie_in & meip_in) |
                (msie_in & msip_in) | (mtie_in & mtip_in));
        w_cause      = 4'd0;
        w_int_or_exc = 1'b0;
        // Synchronous exceptions always pre-empt a pending interrupt.
        if (w_exc) begin
            if (misaligned_instr_in)     w_cause = 4'd0;
            else if (illegal_instr_in)   w_cause = 4'd2;
            else if (ebreak_in)          w_cause = 4'd3;
            else if (ecall_in)           w_cause = 4'd11;
            else if (misaligned_load_in) w_cause = 4'd4;
            else                         w_cause = 4'd6;
        end else if (w_int) begin
            w_int_or_exc = 1'b1;
            if (meie_in & meip_in)      w_cause = 4'd11;
            else if (msie_in & msip_in) w_cause = 4'd3;
            else                        w_cause = 4'd7;
        end
    end

    assign w_take = (r_state == S_OPERATING) & (w_exc | w_int);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_RESET:       w_next = S_OPERATING;
            S_OPERATING: begin
                if (w_take)
                    w_next = S_TRAP_TAKEN;
                else if (instr_valid_in & mret_in)
                    w_next = S_TRAP_RETURN;
            end
            S_TRAP_TAKEN:  w_next = S_OPERATING;
            S_TRAP_RETURN: w_next = S_OPERATING;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state      <= S_RESET;
            r_cause      <= 4'd0;
            r_int_or_exc <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_take) begin
                r_cause      <= w_cause;
                r_int_or_exc <= w_int_or_exc;
            end
        end
    end

    always_comb begin
        pc_src_out    = PC_NEXT;
        set_epc_out   = 1'b0;
        set_cause_out = 1'b0;
        mie_clear_out = 1'b0;
        mie_set_out   = 1'b0;
        flush_out     = 1'b0;
        unique case (r_state)
            S_RESET: begin
                pc_src_out = PC_BOOT;
                flush_out  = 1'b1;
            end
            S_OPERATING: begin
                pc_src_out = PC_NEXT;
            end
            S_TRAP_TAKEN: begin
                pc_src_out    = PC_TRAP;
                set_epc_out   = 1'b1;
                set_cause_out = 1'b1;
                mie_clear_out = 1'b1;
                flush_out     = 1'b1;
            end
            S_TRAP_RETURN: begin
                pc_src_out  = PC_EPC;
                mie_set_out = 1'b1;
                flush_out   = 1'b1;
            end
        endcase
    end

    assign cause_out      = r_cause;
    assign int_or_exc_out = r_int_or_exc;

endmodule
